// File: rtl/hazard_pkg.sv
// Shared constants and FSM type for the pipeline hazard controller.
// Forward-select encodings, x0 register id, RUN/STALL state enum.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Combinational forward-select for one E-stage ALU operand.
// Ports: rs (source reg), rd_m/reg_write_m, rd_w/reg_write_w in; sel out.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic       reg_write_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_w,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_write_m && rd_m != REG_X0 && rd_m == rs)
         sel = FWD_M;
      else if (reg_write_w && rd_w != REG_X0 && rd_w == rs)
         sel = FWD_W;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use stalls, branch flushes.
// Ports: clk, rst, D/E regs, PCSrcE in; ForwardA/BE, StallF/D, FlushD/E out;
// with HAZARD_PERF_CNT_EN defined also stall_cnt/flush_cnt counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic       RegWriteE,
   input  logic       ResultSrcE,
   input  logic       PCSrcE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   logic [4:0] rd_m, rd_w;
   logic       reg_write_m, reg_write_w;
   logic       lw_hz;
   state_t     state, state_n;
   logic [2:0] cnt, cnt_n;

   // E always advances, so the shadow pipe shifts every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_m        <= REG_X0;
         rd_w        <= REG_X0;
         reg_write_m <= 1'b0;
         reg_write_w <= 1'b0;
      end else begin
         rd_m        <= RdE;
         reg_write_m <= RegWriteE;
         rd_w        <= rd_m;
         reg_write_w <= reg_write_m;
      end
   end

   hazard_fwd_sel u_fwd_a (
      .rs          (Rs1E),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .sel         (ForwardAE)
   );

   hazard_fwd_sel u_fwd_b (
      .rs          (Rs2E),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .sel         (ForwardBE)
   );

   assign lw_hz = ResultSrcE && RegWriteE && RdE != REG_X0 &&
                  (RdE == Rs1D || RdE == Rs2D);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // The first stall cycle is spent in RUN, so STALL covers LOAD_LAT-1
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         RUN: begin
            if (!PCSrcE && lw_hz && LOAD_LAT > 1) begin
               state_n = STALL;
               cnt_n   = 3'(LOAD_LAT - 1);
            end
         end
         STALL: begin
            if (PCSrcE) begin
               state_n = RUN;
               cnt_n   = 3'd0;
            end else begin
               cnt_n = cnt - 3'd1;
               if (cnt == 3'd1)
                  state_n = RUN;
            end
         end
      endcase
   end

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               StallF = lw_hz;
               StallD = lw_hz;
               FlushE = lw_hz;
            end
            STALL: begin
               StallF = 1'b1;
               StallD = 1'b1;
               FlushE = 1'b1;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (StallF)
            stall_cnt <= stall_cnt + 1'b1;
         if (FlushD)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Generates operand-forwarding selects for the E-stage ALU.
- Generates load-use stalls, with an optional multi-cycle load latency, and flushes on taken branches.
- Keeps its own shadow copy of the M and W destination registers, so it needs only D/E-stage inputs plus PCSrcE.
- Sits beside the decode stage and drives the F/D pipeline-register enables and the D/E flushes.

Parameters:
LOAD_LAT, 1, number of stall cycles inserted on a load-use hazard (1..7).
CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
clk  input  1  pipeline clock, rising edge.
rst  input  1  synchronous, active-high reset.
Rs1D  input  5  source register 1 of the instruction in D.
Rs2D  input  5  source register 2 of the instruction in D.
Rs1E  input  5  source register 1 of the instruction in E.
Rs2E  input  5  source register 2 of the instruction in E.
RdE  input  5  destination register of the instruction in E.
RegWriteE  input  1  instruction in E writes the register file.
ResultSrcE  input  1  instruction in E is a load.
PCSrcE  input  1  taken branch resolved in E.
ForwardAE  output  2  ALU operand A select: 00 regfile, 01 ResultW, 10 ALUResultM.
ForwardBE  output  2  ALU operand B select, same encoding.
StallF  output  1  hold PC.
StallD  output  1  hold the F/D register.
FlushD  output  1  clear the F/D register.
FlushE  output  1  clear the D/E register (insert bubble).

Behaviour:
- Reset:
  - Rising clk with rst=1 clears RdM, RdW, RegWriteM, RegWriteW, the stall counter, and the optional counters.
  - FSM goes to RUN.
  - Outputs settle to ForwardAE=ForwardBE=00 and StallF=StallD=FlushD=FlushE=0, unless the live inputs call for a flush or stall.
  - rst asserted mid-stall aborts the stall immediately; the next cycle is RUN.
- Shadow pipe, every non-reset edge:
  - RdM<=RdE, RegWriteM<=RegWriteE.
  - RdW<=RdM, RegWriteW<=RegWriteM.
  - E always advances, so there is no gating.
- Forwarding (combinational from the shadow regs and Rs1E/Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==RsxE.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==RsxE.
  - Otherwise 00.
  - M has priority over W. x0 never forwards.
- Load-use detect: lw_hz = ResultSrcE && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM state RUN:
  - PCSrcE=1: FlushD=1, FlushE=1, no stall. Branch wins over a simultaneous lw_hz. Stay in RUN.
  - lw_hz with no PCSrcE: StallF=StallD=FlushE=1.
    - If LOAD_LAT>1, load counter with LOAD_LAT-1 and go to STALL.
    - Otherwise stay in RUN.
- FSM state STALL:
  - StallF=StallD=FlushE=1 every cycle; counter decrements.
  - lw_hz is not re-evaluated.
  - When the counter reaches 0 on this edge, go to RUN.
  - PCSrcE=1 in STALL (illegal; E holds a bubble): flush as in RUN, return to RUN, clear the counter.
- Total stall length for one load-use hazard is exactly LOAD_LAT cycles.
- A back-to-back second load-use after the stall is detected normally.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
  - stall_cnt increments each cycle StallF=1.
  - flush_cnt increments each cycle FlushD=1.
  - Both wrap at 2^CNT_W and clear on rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - FSM enum {RUN, STALL};
  - REG_X0=5'd0.
- One sub-module, hazard_fwd_sel: purely combinational. Takes Rs, RdM, RegWriteM, RdW, RegWriteW and returns the 2-bit select. Instantiated twice, once for A and once for B.

Test Plan:
1. Forward from M/W: cycle n E=add x5 (RegWriteE=1, RdE=5); cycle n+1 Rs1E=5 -> ForwardAE=10; cycle n+2 Rs2E=5 (nothing newer) -> ForwardBE=01.
2. M-over-W priority and x0 rule:
   - RdM=RdW=7, both writing, Rs1E=7 -> ForwardAE=10.
   - RdE=0 load with Rs1D=0 -> no stall, ForwardAE=00.
3. Load-use stall:
   - LOAD_LAT=1, E=lw x3, Rs2D=3 -> StallF=StallD=FlushE=1 for exactly 1 cycle; next cycle ForwardBE=01.
   - LOAD_LAT=3 -> exactly 3 stall cycles.
4. Branch vs load-use: lw_hz and PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=0, FSM stays RUN.
5. Reset mid-operation: LOAD_LAT=4, assert rst in the 2nd stall cycle -> next cycle StallF=0, shadow RegWriteM/W=0, ForwardAE=ForwardBE=00.
6. Perf counters, HAZARD_PERF_CNT_EN with CNT_W=4: 17 stall cycles -> stall_cnt=1 (wrap); 2 taken branches -> flush_cnt=2.
